// File: rtl/gcd_arbiter_pkg.sv
// Shared types for the GCD engine arbiter: controller state encoding and default data width.
package gcd_arb_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BYPASS = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        DONE1  = 3'd4,
        RESP   = 3'd5
    } state_t;

    // The engine is only out of reset while a real computation is in flight.
    function automatic logic engine_owned(state_t s);
        return (s == START) || (s == WAIT) || (s == DONE1);
    endfunction

endpackage

// File: rtl/gcd_arbiter_if.sv
// Requester, response and engine-side signals of the shared GCD arbiter.
interface gcd_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = gcd_arb_pkg::DATA_W_DEF,
    parameter int ID_W   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] opa;
    logic [N_REQ*DATA_W-1:0] opb;
    logic [N_REQ-1:0]        gnt;
    logic                    busy;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_err;
    logic                    eng_rst;
    logic                    eng_go;
    logic [DATA_W-1:0]       eng_a;
    logic [DATA_W-1:0]       eng_b;
    logic                    eng_done;
    logic [DATA_W-1:0]       eng_out;

    modport master (
        input  req, opa, opb, rsp_ready, eng_done, eng_out,
        output gnt, busy, rsp_valid, rsp_id, rsp_data, rsp_err,
               eng_rst, eng_go, eng_a, eng_b
    );

    modport slave (
        output req, opa, opb, rsp_ready, eng_done, eng_out,
        input  gnt, busy, rsp_valid, rsp_id, rsp_data, rsp_err,
               eng_rst, eng_go, eng_a, eng_b
    );
endinterface

// File: rtl/gcd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after the previous winner, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  index,
    output logic             any
);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

    logic [ID_W-1:0] pos;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        pos   = last;
        for (int k = 0; k < N_REQ; k++) begin
            pos = (pos == LAST_IDX) ? '0 : pos + ID_W'(1);
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                index      = pos;
            end
        end
    end
endmodule

// File: rtl/gcd_arbiter.sv
// Shares one GCD engine among N_REQ requesters: round-robin grant, engine sequencing,
// zero-operand bypass, watchdog abort and a valid/ready result port.
module gcd_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic         clk,
    input  logic         rst,
    gcd_arbiter_if.master bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYC);

    state_t              state_reg, state_next;
    logic [ID_W-1:0]     last_reg, last_next;
    logic [ID_W-1:0]     id_reg, id_next;
    logic [N_REQ-1:0]    gnt_reg, gnt_next;
    logic [DATA_W-1:0]   eng_a_reg, eng_a_next;
    logic [DATA_W-1:0]   eng_b_reg, eng_b_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next, cnt_inc;
    logic [DATA_W-1:0]   rsp_data_reg, rsp_data_next;
    logic                rsp_err_reg, rsp_err_next;
    logic                rsp_valid_reg, busy_reg, eng_rst_reg, eng_go_reg;

    logic [DATA_W-1:0]   opa_arr [N_REQ];
    logic [DATA_W-1:0]   opb_arr [N_REQ];
    logic [N_REQ-1:0]    rr_grant;
    logic [ID_W-1:0]     rr_index;
    logic                rr_any;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign opa_arr[gi] = bus.opa[gi*DATA_W +: DATA_W];
        assign opb_arr[gi] = bus.opb[gi*DATA_W +: DATA_W];
    end

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
        .req   (bus.req),
        .last  (last_reg),
        .grant (rr_grant),
        .index (rr_index),
        .any   (rr_any)
    );

    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        id_next       = id_reg;
        gnt_next      = '0;
        eng_a_next    = eng_a_reg;
        eng_b_next    = eng_b_reg;
        cnt_next      = cnt_reg;
        rsp_data_next = rsp_data_reg;
        rsp_err_next  = rsp_err_reg;
        case (state_reg)
            IDLE: begin
                // The gnt pulse cycle doubles as the operand capture cycle.
                if (gnt_reg != '0) begin
                    eng_a_next = opa_arr[id_reg];
                    eng_b_next = opb_arr[id_reg];
                    state_next = (opa_arr[id_reg] == '0 || opb_arr[id_reg] == '0) ? BYPASS : START;
                end else if (rr_any) begin
                    gnt_next  = rr_grant;
                    id_next   = rr_index;
                    last_next = rr_index;
                end
            end
            BYPASS: begin
                rsp_data_next = eng_a_reg | eng_b_reg;
                rsp_err_next  = 1'b0;
                state_next    = RESP;
            end
            START: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                cnt_next = cnt_inc;
                if (bus.eng_done) begin
                    state_next = DONE1;
                end else if (cnt_inc == CNT_MAX) begin
                    rsp_data_next = '0;
                    rsp_err_next  = 1'b1;
                    state_next    = RESP;
                end
            end
            DONE1: begin
                if (bus.eng_done) begin
                    rsp_data_next = bus.eng_out;
                    rsp_err_next  = 1'b0;
                    state_next    = RESP;
                end else begin
                    state_next = WAIT;
                end
            end
            RESP: begin
                if (rsp_valid_reg && bus.rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            last_reg      <= LAST_INIT;
            id_reg        <= '0;
            gnt_reg       <= '0;
            eng_a_reg     <= '0;
            eng_b_reg     <= '0;
            cnt_reg       <= '0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            eng_rst_reg   <= 1'b1;
            eng_go_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_reg      <= last_next;
            id_reg        <= id_next;
            gnt_reg       <= gnt_next;
            eng_a_reg     <= eng_a_next;
            eng_b_reg     <= eng_b_next;
            cnt_reg       <= cnt_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_err_reg   <= rsp_err_next;
            // Status outputs follow the state being entered so they line up with it.
            rsp_valid_reg <= (state_next == RESP);
            busy_reg      <= (state_next != IDLE);
            eng_rst_reg   <= !engine_owned(state_next);
            eng_go_reg    <= (state_next == START);
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.busy      = busy_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = id_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.eng_rst   = eng_rst_reg;
    assign bus.eng_go    = eng_go_reg;
    assign bus.eng_a     = eng_a_reg;
    assign bus.eng_b     = eng_b_reg;
endmodule
